// File: rtl/proc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : proc_pkg
// Description : Shared definitions for the processor control path: sequencer
//               state encoding, phase bit indices and datapath ALU opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
package proc_pkg;

    // Sequencer state encoding
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_F     = 3'd1;
    localparam logic [2:0] S_R     = 3'd2;
    localparam logic [2:0] S_X     = 3'd3;
    localparam logic [2:0] S_M     = 3'd4;
    localparam logic [2:0] S_W     = 3'd5;
    localparam logic [2:0] S_HALT  = 3'd6;
    localparam logic [2:0] S_FAULT = 3'd7;

    // Bit positions inside the one-hot phase vector {w,m,x,r,f}
    localparam int PH_F = 0;
    localparam int PH_R = 1;
    localparam int PH_X = 2;
    localparam int PH_M = 3;
    localparam int PH_W = 4;

    // ALU opcodes consumed by the datapath
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_SRA = 4'd7;

    // True for the states that make forward progress on an instruction
    function automatic logic is_active(input logic [2:0] st);
        return (st == S_F) || (st == S_R) || (st == S_X) ||
               (st == S_M) || (st == S_W);
    endfunction

endpackage
`default_nettype wire

// File: rtl/proc_seq_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : seq_wait_timer
// Description : Memory wait-cycle counter. Counts cycles spent in a memory
//               phase and flags the last cycle at which ready may still come.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_wait_timer #(
    parameter int unsigned WAIT_LIMIT = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned K_W = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [K_W-1:0] LIMIT_K = K_W'(WAIT_LIMIT);
    localparam logic [K_W-1:0] ONE_K   = K_W'(1);

    logic [K_W-1:0] k;

    // Wait index: restart on every phase change, saturate at the limit
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            k <= '0;
        end else if (clear) begin
            k <= '0;
        end else if (enable && (k != LIMIT_K)) begin
            k <= k + ONE_K;
        end
    end

    assign expired = (k == LIMIT_K);

endmodule
`default_nettype wire

// File: rtl/proc_seq.sv
`default_nettype none
// ============================================================================
// Module      : proc_seq
// Description : Multi-cycle control sequencer. Steps fetch/read/exec/mem/write
//               phases with memory handshake, skips unneeded phases, times out
//               stuck accesses and keeps cycle / retired-instruction counters.
// Revision    : 1.0 - initial release
// ============================================================================
module proc_seq
    import proc_pkg::*;
#(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned WAIT_LIMIT = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             run,
    input  logic             dec_mem_rd,
    input  logic             dec_mem_wr,
    input  logic             dec_reg_wr,
    input  logic             dec_branch,
    input  logic             cond_taken,
    input  logic             dec_halt,
    input  logic             dec_illegal,
    input  logic             mem_ready,
    output logic [4:0]       phase,
    output logic             ir_load,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             mem_req,
    output logic             mem_wren,
    output logic             reg_write_en,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    logic [2:0] state;
    logic [2:0] state_next;
    logic       retire;
    logic       expired;
    logic       after_retire_f;

    // After an instruction retires, run decides whether to keep going
    assign after_retire_f = run;

    // Next-state selection and retire detection
    always_comb begin
        state_next = state;
        retire     = 1'b0;
        case (state)
            S_IDLE: begin
                if (run) state_next = S_F;
            end
            S_F: begin
                if (mem_ready)    state_next = S_R;
                else if (expired) state_next = S_FAULT;
            end
            S_R: begin
                if (dec_illegal || (dec_mem_rd && dec_mem_wr)) begin
                    state_next = S_FAULT;
                end else if (dec_halt) begin
                    state_next = S_HALT;
                    retire     = 1'b1;
                end else begin
                    state_next = S_X;
                end
            end
            S_X: begin
                if (dec_mem_rd || dec_mem_wr) begin
                    state_next = S_M;
                end else if (dec_reg_wr) begin
                    state_next = S_W;
                end else begin
                    retire     = 1'b1;
                    state_next = after_retire_f ? S_F : S_IDLE;
                end
            end
            S_M: begin
                if (mem_ready) begin
                    if (dec_mem_rd) begin
                        state_next = S_W;
                    end else begin
                        retire     = 1'b1;
                        state_next = after_retire_f ? S_F : S_IDLE;
                    end
                end else if (expired) begin
                    state_next = S_FAULT;
                end
            end
            S_W: begin
                retire     = 1'b1;
                state_next = after_retire_f ? S_F : S_IDLE;
            end
            S_HALT:  state_next = S_HALT;
            S_FAULT: state_next = S_FAULT;
            default: state_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= S_IDLE;
        else        state <= state_next;
    end

    // Wait timer restarts on any state change and runs while in F or M
    seq_wait_timer #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_wait_timer (
        .clk     (clk),
        .n_rst   (n_rst),
        .clear   (state_next != state),
        .enable  ((state == S_F) || (state == S_M)),
        .expired (expired)
    );

    // Active-cycle and retired-instruction counters, both wrap silently
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (is_active(state)) cycle_cnt   <= cycle_cnt + ONE_CNT;
            if (retire)           instret_cnt <= instret_cnt + ONE_CNT;
        end
    end

    // Phase vector decoded from the state register
    always_comb begin
        phase = '0;
        case (state)
            S_F:     phase[PH_F] = 1'b1;
            S_R:     phase[PH_R] = 1'b1;
            S_X:     phase[PH_X] = 1'b1;
            S_M:     phase[PH_M] = 1'b1;
            S_W:     phase[PH_W] = 1'b1;
            default: phase = '0;
        endcase
    end

    assign mem_req      = (state == S_F) || (state == S_M);
    assign mem_wren     = (state == S_M) && dec_mem_wr;
    assign reg_write_en = (state == S_W);
    assign halted       = (state == S_HALT);
    assign fault        = (state == S_FAULT);

    // Fetch completion latches the instruction and advances pc together
    assign ir_load = (state == S_F) && mem_ready;
    assign pc_inc  = (state == S_F) && mem_ready;
    assign pc_load = (state == S_X) && dec_branch && cond_taken;

endmodule
`default_nettype wire

// File: tb/tb_proc_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_proc_seq
// Description : Scoreboard bench for proc_seq. Stimulus pushes per-cycle
//               expectations; a monitor pops and compares on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_proc_seq;

    logic        clk;
    logic        n_rst;
    logic        run, dec_mem_rd, dec_mem_wr, dec_reg_wr, dec_branch;
    logic        cond_taken, dec_halt, dec_illegal, mem_ready;
    logic [4:0]  phase;
    logic        ir_load, pc_inc, pc_load, mem_req, mem_wren;
    logic        reg_write_en, halted, fault;
    logic [31:0] cycle_cnt, instret_cnt;
    logic [7:0]  ctrl;

    proc_seq #(
        .CNT_W      (32),
        .WAIT_LIMIT (8)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .run          (run),
        .dec_mem_rd   (dec_mem_rd),
        .dec_mem_wr   (dec_mem_wr),
        .dec_reg_wr   (dec_reg_wr),
        .dec_branch   (dec_branch),
        .cond_taken   (cond_taken),
        .dec_halt     (dec_halt),
        .dec_illegal  (dec_illegal),
        .mem_ready    (mem_ready),
        .phase        (phase),
        .ir_load      (ir_load),
        .pc_inc       (pc_inc),
        .pc_load      (pc_load),
        .mem_req      (mem_req),
        .mem_wren     (mem_wren),
        .reg_write_en (reg_write_en),
        .halted       (halted),
        .fault        (fault),
        .cycle_cnt    (cycle_cnt),
        .instret_cnt  (instret_cnt)
    );

    assign ctrl = {ir_load, pc_inc, pc_load, mem_req, mem_wren, reg_write_en, halted, fault};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Phase patterns {w,m,x,r,f}
    localparam logic [4:0] P0 = 5'b00000;
    localparam logic [4:0] PF = 5'b00001;
    localparam logic [4:0] PR = 5'b00010;
    localparam logic [4:0] PX = 5'b00100;
    localparam logic [4:0] PM = 5'b01000;
    localparam logic [4:0] PW = 5'b10000;

    // ctrl = {ir_load,pc_inc,pc_load,mem_req,mem_wren,reg_write_en,halted,fault}
    localparam logic [7:0] C_NONE  = 8'b0000_0000;
    localparam logic [7:0] C_FETCH = 8'b1101_0000;
    localparam logic [7:0] C_FWAIT = 8'b0001_0000;
    localparam logic [7:0] C_MRD   = 8'b0001_0000;
    localparam logic [7:0] C_MWR   = 8'b0001_1000;
    localparam logic [7:0] C_W     = 8'b0000_0100;
    localparam logic [7:0] C_BR    = 8'b0010_0000;
    localparam logic [7:0] C_HALT  = 8'b0000_0010;
    localparam logic [7:0] C_FAULT = 8'b0000_0001;

    typedef struct {
        string      nm;
        logic [4:0] ph;
        logic [7:0] ct;
        int         cy;
        int         ins;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Monitor: one expectation per sampled cycle
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            if (phase !== e.ph) begin
                bad++;
                $display("FAIL %s phase got=%b want=%b", e.nm, phase, e.ph);
            end
            total++;
            if (ctrl !== e.ct) begin
                bad++;
                $display("FAIL %s ctrl got=%b want=%b", e.nm, ctrl, e.ct);
            end
            total++;
            if (cycle_cnt !== 32'(e.cy) || instret_cnt !== 32'(e.ins)) begin
                bad++;
                $display("FAIL %s counters got=%0d/%0d want=%0d/%0d",
                         e.nm, cycle_cnt, instret_cnt, e.cy, e.ins);
            end
        end
    end

    // Queue one expectation for the current cycle, then advance a clock
    task automatic step(input string nm, input logic [4:0] ph, input logic [7:0] ct,
                        input int cy, input int ins);
        exp_t e;
        e.nm = nm; e.ph = ph; e.ct = ct; e.cy = cy; e.ins = ins;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_dec();
        dec_mem_rd = 0; dec_mem_wr = 0; dec_reg_wr = 0; dec_branch = 0;
        cond_taken = 0; dec_halt = 0; dec_illegal = 0;
    endtask

    initial begin
        n_rst = 0; run = 0; mem_ready = 0;
        clear_dec();
        @(posedge clk);
        #1;

        // Reset holds everything at zero even with run and ready high
        run = 1; mem_ready = 1;
        step("reset", P0, C_NONE, 0, 0);

        // ALU op: F R X W
        n_rst = 1; dec_reg_wr = 1;
        step("alu_idle", P0, C_NONE, 0, 0);
        step("alu_f", PF, C_FETCH, 0, 0);
        step("alu_r", PR, C_NONE, 1, 0);
        step("alu_x", PX, C_NONE, 2, 0);
        step("alu_w", PW, C_W, 3, 0);
        step("ld_f", PF, C_FETCH, 4, 1);

        // Load with three wait cycles in M
        dec_mem_rd = 1;
        step("ld_r", PR, C_NONE, 5, 1);
        step("ld_x", PX, C_NONE, 6, 1);
        mem_ready = 0;
        step("ld_m0", PM, C_MRD, 7, 1);
        step("ld_m1", PM, C_MRD, 8, 1);
        step("ld_m2", PM, C_MRD, 9, 1);
        mem_ready = 1;
        step("ld_m3", PM, C_MRD, 10, 1);
        step("ld_w", PW, C_W, 11, 1);
        step("st_f", PF, C_FETCH, 12, 2);

        // Store: F R X M, no W
        clear_dec(); dec_mem_wr = 1;
        step("st_r", PR, C_NONE, 13, 2);
        step("st_x", PX, C_NONE, 14, 2);
        step("st_m", PM, C_MWR, 15, 2);
        step("bt_f", PF, C_FETCH, 16, 3);

        // Taken branch
        clear_dec(); dec_branch = 1; cond_taken = 1;
        step("bt_r", PR, C_NONE, 17, 3);
        step("bt_x", PX, C_BR, 18, 3);
        step("bn_f", PF, C_FETCH, 19, 4);

        // Not-taken branch
        cond_taken = 0;
        step("bn_r", PR, C_NONE, 20, 4);
        step("bn_x", PX, C_NONE, 21, 4);
        step("nop_f", PF, C_FETCH, 22, 5);

        // No-write op with run dropped: retire to IDLE and stay there
        clear_dec(); run = 0;
        step("nop_r", PR, C_NONE, 23, 5);
        step("nop_x", PX, C_NONE, 24, 5);
        step("idle0", P0, C_NONE, 25, 6);
        run = 1; mem_ready = 0;
        step("idle1", P0, C_NONE, 25, 6);

        // Fetch timeout: 9 F cycles then FAULT with frozen counters
        for (int k = 0; k < 9; k++) step("to_f", PF, C_FWAIT, 25 + k, 6);
        step("to_fault", P0, C_FAULT, 34, 6);
        mem_ready = 1;
        step("to_fault_hold", P0, C_FAULT, 34, 6);

        // Reset, then ready arriving exactly at k=8 is accepted; halt
        n_rst = 0; mem_ready = 0;
        step("reset2", P0, C_NONE, 0, 0);
        n_rst = 1;
        step("k8_idle", P0, C_NONE, 0, 0);
        for (int k = 0; k < 8; k++) step("k8_wait", PF, C_FWAIT, k, 0);
        mem_ready = 1;
        step("k8_f", PF, C_FETCH, 8, 0);
        dec_halt = 1;
        step("h_r", PR, C_NONE, 9, 0);
        step("h_halt", P0, C_HALT, 10, 1);
        step("h_hold", P0, C_HALT, 10, 1);

        // Illegal opcode faults from R without retiring
        n_rst = 0;
        step("reset3", P0, C_NONE, 0, 0);
        n_rst = 1; clear_dec(); dec_illegal = 1;
        step("il_idle", P0, C_NONE, 0, 0);
        step("il_f", PF, C_FETCH, 0, 0);
        step("il_r", PR, C_NONE, 1, 0);
        step("il_fault", P0, C_FAULT, 2, 0);

        // Reset asserted mid-M aborts at once
        n_rst = 0;
        step("reset4", P0, C_NONE, 0, 0);
        n_rst = 1; clear_dec(); dec_mem_rd = 1; dec_reg_wr = 1;
        step("am_idle", P0, C_NONE, 0, 0);
        step("am_f", PF, C_FETCH, 0, 0);
        step("am_r", PR, C_NONE, 1, 0);
        mem_ready = 0;
        step("am_x", PX, C_NONE, 2, 0);
        step("am_m0", PM, C_MRD, 3, 0);
        step("am_m1", PM, C_MRD, 4, 0);
        n_rst = 0; mem_ready = 1;
        step("am_abort", P0, C_NONE, 0, 0);
        step("am_hold", P0, C_NONE, 0, 0);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain pending got=%0d want=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
